// File: rtl/tpu_host_buffer.sv
// Host-side operand/result buffer for the 8x8 systolic array: the host fills A/B over a byte bus,
// the buffer streams element pairs to the core and collects 16-bit results for host readback.
module tpu_host_buffer #(
   parameter int ELEMS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  host_addr,
   input  logic [7:0]  host_wdata,
   input  logic        host_we,
   input  logic        host_start,
   output logic [7:0]  host_rdata,
   output logic        host_busy,
   output logic        host_done,
   output logic [7:0]  core_a_data,
   output logic [7:0]  core_b_data,
   output logic        core_valid,
   output logic        core_last,
   input  logic        core_ready,
   input  logic [15:0] res_data,
   input  logic        res_valid
);

   localparam int KW = $clog2(ELEMS);
   localparam logic [KW-1:0] K_LAST = KW'(ELEMS - 1);
   localparam logic [KW:0]   R_FULL = (KW + 1)'(ELEMS);

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, DONE} state_t;

   state_t        state_reg, state_next;
   logic [KW-1:0] k_reg, k_next;
   logic [KW:0]   r_reg, r_next;
   logic [7:0]    rdata_reg, rdata_next;

   logic [7:0]    a_mem   [ELEMS];
   logic [7:0]    b_mem   [ELEMS];
   logic [15:0]   res_mem [ELEMS];

   logic [KW-1:0] idx;
   logic          host_open;
   logic          buf_we;
   logic          res_we;
   logic          streaming;

   assign idx       = host_addr[KW-1:0];
   assign host_open = (state_reg == IDLE) || (state_reg == DONE);
   assign buf_we    = host_we && !host_addr[7] && host_open;
   assign streaming = (state_reg == STREAM);
   assign res_we    = res_valid && (streaming || state_reg == WAIT_RES) && (r_reg != R_FULL);

   // Buffers carry no reset so they map onto RAM; their content after reset is unspecified.
   always_ff @(posedge clk) begin
      if (buf_we && !host_addr[6])
         a_mem[idx] <= host_wdata;
      if (buf_we && host_addr[6])
         b_mem[idx] <= host_wdata;
      if (res_we)
         res_mem[r_reg[KW-1:0]] <= res_data;
   end

   always_comb begin
      rdata_next = '0;
      unique case (host_addr[7:6])
         2'b00:   rdata_next = a_mem[idx];
         2'b01:   rdata_next = b_mem[idx];
         2'b10:   rdata_next = res_mem[idx][7:0];
         default: rdata_next = res_mem[idx][15:8];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         k_reg     <= '0;
         r_reg     <= '0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         r_reg     <= r_next;
         rdata_reg <= rdata_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      r_next     = r_reg;
      if (res_we)
         r_next = r_reg + 1'b1;
      unique case (state_reg)
         IDLE, DONE: begin
            if (host_start) begin
               state_next = STREAM;
               k_next     = '0;
               r_next     = '0;
            end else if (state_reg == DONE && buf_we) begin
               state_next = IDLE;
            end
         end
         STREAM: begin
            if (core_ready) begin
               if (k_reg == K_LAST)
                  state_next = WAIT_RES;
               else
                  k_next = k_reg + 1'b1;
            end
         end
         default: begin
            // Results that finished during STREAM are honoured here, one cycle after the last handshake.
            if (r_reg == R_FULL)
               state_next = DONE;
         end
      endcase
   end

   // Core side reads the operand arrays combinationally so a write landing with host_start shows at k=0.
   assign core_valid  = streaming;
   assign core_last   = streaming && (k_reg == K_LAST);
   assign core_a_data = streaming ? a_mem[k_reg] : 8'h00;
   assign core_b_data = streaming ? b_mem[k_reg] : 8'h00;

   assign host_rdata  = rdata_reg;
   assign host_busy   = streaming || (state_reg == WAIT_RES);
   assign host_done   = (state_reg == DONE);

endmodule

// File: tb/tb_tpu_host_buffer.sv
// Directed self-checking bench for tpu_host_buffer: host access, streaming, stalls, overflow, reset.
module tb_tpu_host_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  host_addr = '0;
   logic [7:0]  host_wdata = '0;
   logic        host_we = 1'b0;
   logic        host_start = 1'b0;
   logic [7:0]  host_rdata;
   logic        host_busy;
   logic        host_done;
   logic [7:0]  core_a_data;
   logic [7:0]  core_b_data;
   logic        core_valid;
   logic        core_last;
   logic        core_ready = 1'b0;
   logic [15:0] res_data = '0;
   logic        res_valid = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tpu_host_buffer #(.ELEMS(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_we     (host_we),
      .host_start  (host_start),
      .host_rdata  (host_rdata),
      .host_busy   (host_busy),
      .host_done   (host_done),
      .core_a_data (core_a_data),
      .core_b_data (core_b_data),
      .core_valid  (core_valid),
      .core_last   (core_last),
      .core_ready  (core_ready),
      .res_data    (res_data),
      .res_valid   (res_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [7:0] a, input logic [7:0] d);
      host_addr  = a;
      host_wdata = d;
      host_we    = 1'b1;
      tick();
      host_we    = 1'b0;
   endtask

   task automatic host_read(input logic [7:0] a, output logic [7:0] d);
      host_addr = a;
      tick();
      d = host_rdata;
      $display("read  addr=%h data=%h", a, d);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if ({host_rdata, host_busy, host_done} !== 10'h0) begin
         errors++;
         $display("FAIL reset_host: rdata/busy/done=%h expected 000", {host_rdata, host_busy, host_done});
      end
      checks++;
      if ({core_valid, core_last, core_a_data, core_b_data} !== 18'h0) begin
         errors++;
         $display("FAIL reset_core: valid/last/a/b=%h expected 00000", {core_valid, core_last, core_a_data, core_b_data});
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      $display("reset released");
   endtask

   task automatic test_write_read();
      logic [7:0] rd;
      for (int i = 0; i < 64; i++) begin
         host_write(8'(i), 8'(i));
         host_write(8'(8'h40 + i), 8'(8'hFF - i));
      end
      $display("wrote A[i]=i, B[i]=ff-i");
      host_read(8'h05, rd);
      checks++;
      if (rd !== 8'h05) begin errors++; $display("FAIL read_a05: got %h expected 05", rd); end
      host_addr = 8'h45;
      #1;
      checks++;
      if (host_rdata !== 8'h05) begin errors++; $display("FAIL read_latency: got %h expected 05 (old addr)", host_rdata); end
      tick();
      checks++;
      if (host_rdata !== 8'hFA) begin errors++; $display("FAIL read_b45: got %h expected fa", host_rdata); end
      host_read(8'h3F, rd);
      checks++;
      if (rd !== 8'h3F) begin errors++; $display("FAIL read_a3f: got %h expected 3f", rd); end
      host_read(8'h7F, rd);
      checks++;
      if (rd !== 8'hC0) begin errors++; $display("FAIL read_b7f: got %h expected c0", rd); end
   endtask

   task automatic test_stream();
      int cyc = 0;
      logic [7:0] rd;
      host_start = 1'b1;
      core_ready = 1'b1;
      tick();
      host_start = 1'b0;
      while (core_valid === 1'b1 && cyc < 200) begin
         checks++;
         if (core_a_data !== 8'(cyc) || core_b_data !== 8'(8'hFF - cyc) || core_last !== (cyc == 63) || host_busy !== 1'b1) begin
            errors++;
            $display("FAIL stream_elem%0d: a=%h b=%h last=%b busy=%b expected a=%h b=%h last=%b busy=1",
                     cyc, core_a_data, core_b_data, core_last, host_busy, 8'(cyc), 8'(8'hFF - cyc), (cyc == 63));
         end
         res_valid = 1'b1;
         res_data  = 16'h1200 + 16'(cyc);
         tick();
         cyc++;
      end
      res_valid  = 1'b0;
      core_ready = 1'b0;
      $display("stream finished after %0d cycles", cyc);
      checks++;
      if (cyc != 64) begin errors++; $display("FAIL stream_len: got %0d expected 64", cyc); end
      checks++;
      if (host_busy !== 1'b1 || host_done !== 1'b0) begin
         errors++; $display("FAIL wait_res: busy=%b done=%b expected busy=1 done=0", host_busy, host_done);
      end
      tick();
      checks++;
      if (host_done !== 1'b1 || host_busy !== 1'b0) begin
         errors++; $display("FAIL done_entry: busy=%b done=%b expected busy=0 done=1", host_busy, host_done);
      end
      host_read(8'h83, rd);
      checks++;
      if (rd !== 8'h03) begin errors++; $display("FAIL read_res83: got %h expected 03", rd); end
      host_read(8'hC3, rd);
      checks++;
      if (rd !== 8'h12) begin errors++; $display("FAIL read_resc3: got %h expected 12", rd); end
      host_read(8'hBF, rd);
      checks++;
      if (rd !== 8'h3F) begin errors++; $display("FAIL read_resbf: got %h expected 3f", rd); end
      host_write(8'h85, 8'h55);
      checks++;
      if (host_done !== 1'b1) begin errors++; $display("FAIL ro_write_state: done=%b expected 1", host_done); end
      host_read(8'h85, rd);
      checks++;
      if (rd !== 8'h05) begin errors++; $display("FAIL ro_write_data: got %h expected 05", rd); end
   endtask

   task automatic test_stall_ignore();
      int cyc = 0;
      int exp_k = 0;
      logic hs;
      logic [7:0] rd;
      host_start = 1'b1;
      tick();
      host_start = 1'b0;
      while (core_valid === 1'b1 && cyc < 300) begin
         checks++;
         if (core_a_data !== 8'(exp_k) || core_b_data !== 8'(8'hFF - exp_k) || core_last !== (exp_k == 63)) begin
            errors++;
            $display("FAIL stall_k%0d_c%0d: a=%h b=%h last=%b expected a=%h b=%h last=%b",
                     exp_k, cyc, core_a_data, core_b_data, core_last, 8'(exp_k), 8'(8'hFF - exp_k), (exp_k == 63));
         end
         core_ready = (cyc % 2 == 0);
         if (cyc == 20) begin
            host_addr = 8'h10; host_wdata = 8'hAA; host_we = 1'b1; host_start = 1'b1;
         end else begin
            host_we = 1'b0; host_start = 1'b0;
         end
         hs = core_ready;
         tick();
         cyc++;
         if (hs) exp_k++;
      end
      core_ready = 1'b0;
      host_we    = 1'b0;
      host_start = 1'b0;
      $display("stalled stream finished after %0d cycles, %0d handshakes", cyc, exp_k);
      checks++;
      if (cyc < 127 || cyc > 128 || exp_k != 64) begin
         errors++; $display("FAIL stall_len: cycles=%0d hs=%0d expected 127..128 cycles, 64 hs", cyc, exp_k);
      end
      checks++;
      if (host_busy !== 1'b1) begin errors++; $display("FAIL wait_no_res: busy=%b expected 1", host_busy); end
      host_read(8'h10, rd);
      checks++;
      if (rd !== 8'h10) begin errors++; $display("FAIL dropped_write: got %h expected 10", rd); end
   endtask

   task automatic test_overflow();
      int rises = 0;
      logic prev_done;
      logic [7:0] rd;
      prev_done = host_done;
      for (int j = 0; j < 70; j++) begin
         res_valid = (j < 65);
         res_data  = (j == 64) ? 16'hBEEF : 16'h3400 + 16'(j);
         tick();
         if (host_done === 1'b1 && prev_done !== 1'b1) rises++;
         prev_done = host_done;
      end
      res_valid = 1'b0;
      $display("65 result pulses, done rises=%0d", rises);
      checks++;
      if (rises != 1 || host_done !== 1'b1) begin
         errors++; $display("FAIL done_once: rises=%0d done=%b expected 1 and 1", rises, host_done);
      end
      host_read(8'h80, rd);
      checks++;
      if (rd !== 8'h00) begin errors++; $display("FAIL ovf_res0_lo: got %h expected 00", rd); end
      host_read(8'hC0, rd);
      checks++;
      if (rd !== 8'h34) begin errors++; $display("FAIL ovf_res0_hi: got %h expected 34", rd); end
      host_read(8'hBF, rd);
      checks++;
      if (rd !== 8'h3F) begin errors++; $display("FAIL ovf_res63_lo: got %h expected 3f", rd); end
   endtask

   task automatic test_done_write();
      logic [7:0] rd;
      host_write(8'h20, 8'h99);
      checks++;
      if (host_done !== 1'b0 || host_busy !== 1'b0) begin
         errors++; $display("FAIL done_to_idle: done=%b busy=%b expected 0 0", host_done, host_busy);
      end
      host_read(8'hC0, rd);
      checks++;
      if (rd !== 8'h34) begin errors++; $display("FAIL res_retained: got %h expected 34", rd); end
      host_read(8'h20, rd);
      checks++;
      if (rd !== 8'h99) begin errors++; $display("FAIL idle_write: got %h expected 99", rd); end
   endtask

   task automatic test_write_with_start();
      host_addr  = 8'h00;
      host_wdata = 8'h77;
      host_we    = 1'b1;
      host_start = 1'b1;
      core_ready = 1'b0;
      tick();
      host_we    = 1'b0;
      host_start = 1'b0;
      $display("write+start same cycle: a=%h b=%h valid=%b", core_a_data, core_b_data, core_valid);
      checks++;
      if (core_valid !== 1'b1 || core_a_data !== 8'h77 || core_b_data !== 8'hFF || core_last !== 1'b0) begin
         errors++;
         $display("FAIL write_start: valid=%b a=%h b=%h last=%b expected 1 77 ff 0", core_valid, core_a_data, core_b_data, core_last);
      end
      tick();
      checks++;
      if (core_a_data !== 8'h77 || core_valid !== 1'b1) begin
         errors++; $display("FAIL hold_stalled: valid=%b a=%h expected 1 77", core_valid, core_a_data);
      end
   endtask

   task automatic test_reset_mid();
      host_addr  = 8'h01;
      core_ready = 1'b1;
      repeat (30) tick();
      core_ready = 1'b0;
      checks++;
      if (core_a_data !== 8'h1E || core_b_data !== 8'hE1 || host_rdata !== 8'h01) begin
         errors++; $display("FAIL pre_reset_k30: a=%h b=%h rdata=%h expected 1e e1 01", core_a_data, core_b_data, host_rdata);
      end
      rst_n = 1'b0;
      #1;
      $display("reset at k=30");
      checks++;
      if ({host_rdata, host_busy, host_done, core_valid, core_last, core_a_data, core_b_data} !== 28'h0) begin
         errors++;
         $display("FAIL mid_reset: rdata=%h busy=%b done=%b valid=%b last=%b a=%h b=%h expected all 0",
                  host_rdata, host_busy, host_done, core_valid, core_last, core_a_data, core_b_data);
      end
      #1 rst_n = 1'b1;
      tick();
      host_write(8'h00, 8'h5A);
      host_write(8'h40, 8'h3C);
      host_start = 1'b1;
      tick();
      host_start = 1'b0;
      checks++;
      if (core_valid !== 1'b1 || core_a_data !== 8'h5A || core_b_data !== 8'h3C || host_busy !== 1'b1) begin
         errors++;
         $display("FAIL restart_k0: valid=%b a=%h b=%h busy=%b expected 1 5a 3c 1", core_valid, core_a_data, core_b_data, host_busy);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_stream();
      test_stall_ignore();
      test_overflow();
      test_done_write();
      test_write_with_start();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tpu_host_buffer.md
TPU_HOST_BUFFER -- requirements
Module: tpu_host_buffer

Interface
REQ-001 Parameter: ELEMS, 64, elements per operand matrix (8x8); the address map below SHALL hold only for 64.
REQ-002 clk  in  1  system clock (100 MHz); single clock domain.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 host_addr  in  8  byte address from the host interface.
REQ-005 host_wdata  in  8  write data.
REQ-006 host_we  in  1  one-cycle write strobe.
REQ-007 host_start  in  1  one-cycle start-computation strobe.
REQ-008 host_rdata  out  8  read data for host_addr.
REQ-009 host_busy  out  1  computation in progress.
REQ-010 host_done  out  1  result set complete.
REQ-011 core_a_data  out  8  A-matrix element to the array core.
REQ-012 core_b_data  out  8  B-matrix element to the array core.
REQ-013 core_valid  out  1  core_a_data/core_b_data valid.
REQ-014 core_last  out  1  marks element 63.
REQ-015 core_ready  in  1  core accepts the current element.
REQ-016 res_data  in  16  result word from the core.
REQ-017 res_valid  in  1  res_data valid, one word per cycle.

Function
REQ-018 Address map SHALL be: 0x00-0x3F A buffer (r/w), 0x40-0x7F B buffer (r/w), 0x80-0xBF result[i][7:0] (read-only), 0xC0-0xFF result[i][15:8] (read-only).
REQ-019 host_rdata SHALL equal the byte at the host_addr sampled on the previous clock edge (1-cycle latency), in every state.
REQ-020 A host_we to 0x00-0x7F SHALL update the buffer at that clock edge only in IDLE or DONE; writes in STREAM/WAIT_RES and writes to 0x80-0xFF SHALL be dropped.
REQ-021 FSM states SHALL be IDLE, STREAM, WAIT_RES, DONE.
REQ-022 IDLE/DONE + host_start -> STREAM; index k, result count r and host_done cleared to 0.
REQ-023 host_start in STREAM or WAIT_RES SHALL be ignored.
REQ-024 In STREAM, core_valid=1, core_a_data=A[k], core_b_data=B[k], core_last=(k==63); outputs SHALL hold stable while core_ready=0.
REQ-025 core_valid&core_ready in STREAM: k<63 -> k+1; k==63 -> WAIT_RES, core_valid=0 next cycle.
REQ-026 res_valid in STREAM or WAIT_RES with r<64 SHALL store res_data at result[r] and increment r; res_valid in IDLE/DONE or with r==64 SHALL be ignored.
REQ-027 WAIT_RES with r==64 -> DONE next cycle; r reaching 64 while still in STREAM SHALL be held and DONE entered one cycle after the k==63 handshake.
REQ-028 host_busy SHALL be 1 exactly in STREAM and WAIT_RES; host_done SHALL be 1 exactly in DONE.
REQ-029 DONE + host_we (accepted) -> IDLE, host_done cleared; result buffer retained.
REQ-030 host_we and host_start in the same IDLE cycle: the write SHALL land, and STREAM element 0 SHALL reflect it.
REQ-031 core_valid, core_last SHALL be 0 and core data outputs 0 outside STREAM.
REQ-032 Total STREAM duration with core_ready held high SHALL be exactly 64 cycles.

Reset
REQ-033 rst_n low SHALL force IDLE, k=0, r=0, host_rdata=0, host_busy=0, host_done=0, core_valid=0, core_last=0, core data outputs 0, immediately and regardless of state (mid-operation included).
REQ-034 Buffer contents SHALL be undefined after reset; the bench SHALL not rely on them.

Verification
REQ-035 Write A[i]=i, B[i]=0xFF-i, read 0x05 and 0x45 -> host_rdata 0x05 and 0xFA one cycle after address.
REQ-036 Start with core_ready=1, core returns res_data=0x1200+i -> 64 elements, core_last on cycle 64, host_done=1; reads 0x83 -> 0x03, 0xC3 -> 0x12.
REQ-037 core_ready toggling 1/0 every cycle -> k advances only on handshakes, data stable while stalled, STREAM lasts 127-128 cycles.
REQ-038 host_we 0x10 <= 0xAA and host_start during STREAM -> A[0x10] unchanged, no restart, k continues.
REQ-039 65 res_valid pulses -> only first 64 stored, r stays 64, DONE entered once.
REQ-040 rst_n asserted at k=30 -> all outputs at reset values same cycle; subsequent start streams from k=0.
